// File: rtl/adder_arbiter.sv
// Three-requester round-robin front end for a shared 4-phase adder.
// Every output is registered, and ADD_REQ is held low for at least two cycles between operations.
module adder_arbiter #(
  parameter int W   = 9,
  parameter int TMO = 15
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [2:0]     REQ,
  input  logic [3*W-1:0] A_IN,
  input  logic [3*W-1:0] B_IN,
  output logic [2:0]     ACK,
  output logic [W-1:0]   Z_OUT,
  output logic           COUT_OUT,
  output logic           ERR,
  output logic           BUSY,
  output logic [W-1:0]   ADD_A,
  output logic [W-1:0]   ADD_B,
  output logic           ADD_REQ,
  input  logic [W-1:0]   ADD_Z,
  input  logic           ADD_COUT,
  input  logic           ADD_ACK
);

  // state   | meaning
  // IDLE    | wait for an eligible requester
  // ISSUE   | ADD_REQ high, wait for ADD_ACK or timeout
  // RELEASE | ADD_REQ low, adder returns to its compute state
  // GAP     | one more low cycle before the next issue
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  localparam int CW = $clog2(TMO + 1);

  logic [1:0]   state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   gnt_q, gnt_d;
  logic [2:0]   wl_q, wl_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [2:0]   ack_q, ack_d;
  logic         err_q, err_d;
  logic         add_req_q, add_req_d;
  logic [W-1:0] add_a_q, add_a_d;
  logic [W-1:0] add_b_q, add_b_d;
  logic [W-1:0] z_q, z_d;
  logic         cout_q, cout_d;
  logic         busy_q, busy_d;

  logic [2:0]   elig;
  logic         found;
  logic [1:0]   pick;
  logic [2:0]   set_wl;

  assign elig = REQ & ~wl_q;

  // Round-robin search starting at ptr_q.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= 3) idx = idx - 3;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx[1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    tmo_d     = tmo_q;
    ack_d     = 3'b000;
    err_d     = 1'b0;
    add_req_d = add_req_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    z_d       = z_q;
    cout_d    = cout_q;
    set_wl    = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d     = pick;
          ptr_d     = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
          add_a_d   = A_IN[int'(pick)*W +: W];
          add_b_d   = B_IN[int'(pick)*W +: W];
          add_req_d = 1'b1;
          tmo_d     = CW'(TMO - 1);
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ADD_ACK || tmo_q == '0) begin
          if (ADD_ACK) begin
            z_d    = ADD_Z;
            cout_d = ADD_COUT;
          end else begin
            z_d    = '0;
            cout_d = 1'b0;
            err_d  = 1'b1;
          end
          ack_d     = 3'b001 << gnt_q;
          set_wl    = 3'b001 << gnt_q;
          add_req_d = 1'b0;
          state_d   = S_RELEASE;
        end else begin
          tmo_d = tmo_q - CW'(1);
        end
      end
      S_RELEASE: state_d = S_GAP;
      default:   state_d = S_IDLE;
    endcase
    // A fresh completion wins over the low-REQ clear in the same cycle.
    wl_d   = set_wl | (wl_q & REQ);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_RELEASE;
      ptr_q     <= 2'd0;
      gnt_q     <= 2'd0;
      wl_q      <= 3'b000;
      tmo_q     <= '0;
      ack_q     <= 3'b000;
      err_q     <= 1'b0;
      add_req_q <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      z_q       <= '0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      wl_q      <= wl_d;
      tmo_q     <= tmo_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      add_req_q <= add_req_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      z_q       <= z_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
    end
  end

  assign ACK      = ack_q;
  assign ERR      = err_q;
  assign ADD_REQ  = add_req_q;
  assign ADD_A    = add_a_q;
  assign ADD_B    = add_b_q;
  assign Z_OUT    = z_q;
  assign COUT_OUT = cout_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a simple handshaking adder model.
module tb_adder_arbiter;
  localparam int W = 9;

  logic           CLK = 1'b0;
  logic           RST;
  logic [2:0]     REQ;
  logic [3*W-1:0] A_IN, B_IN;
  logic [2:0]     ACK;
  logic [W-1:0]   Z_OUT;
  logic           COUT_OUT, ERR, BUSY;
  logic [W-1:0]   ADD_A, ADD_B;
  logic           ADD_REQ;
  logic [W-1:0]   ADD_Z;
  logic           ADD_COUT;
  logic           ADD_ACK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  adder_arbiter #(.W(W), .TMO(15)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
    .ACK(ACK), .Z_OUT(Z_OUT), .COUT_OUT(COUT_OUT), .ERR(ERR), .BUSY(BUSY),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_REQ(ADD_REQ),
    .ADD_Z(ADD_Z), .ADD_COUT(ADD_COUT), .ADD_ACK(ADD_ACK)
  );

  always #5 CLK = ~CLK;

  // Adder model: acks one cycle after seeing ADD_REQ; en_m=0 silences it.
  logic ack_m = 1'b0;
  logic en_m  = 1'b1;
  logic spur  = 1'b0;
  logic [W-1:0] z_m = '0;
  logic c_m = 1'b0;
  always_ff @(posedge CLK) begin
    ack_m      <= ADD_REQ && !ack_m;
    {c_m, z_m} <= {1'b0, ADD_A} + {1'b0, ADD_B};
  end
  assign ADD_ACK  = (ack_m && en_m) || spur;
  assign ADD_Z    = z_m;
  assign ADD_COUT = c_m;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 20) begin tick(); n++; end
    chk("wait_idle", {31'd0, BUSY}, 0);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (ACK == 3'b000 && n < 60) begin tick(); n++; end
  endtask

  initial begin
    int n, hi, low, k, last, idx, seen;
    logic [W-1:0] exp_z;
    RST  = 1'b1;
    REQ  = 3'b000;
    A_IN = {9'h055, 9'h1FF, 9'h0FF};
    B_IN = {9'h0AA, 9'h001, 9'h001};
    tick(); tick();
    chk("rst_ack", ACK, 0);
    chk("rst_err", ERR, 0);
    chk("rst_add_req", ADD_REQ, 0);
    chk("rst_add_a", ADD_A, 0);
    chk("rst_z", Z_OUT, 0);
    chk("rst_cout", COUT_OUT, 0);
    chk("rst_busy", BUSY, 1);
    RST = 1'b0;
    n = 0;
    while (BUSY && n < 20) begin tick(); n++; end
    chk("rst_to_idle_cycles", n, 2);

    // single request
    REQ = 3'b001;
    tick();
    chk("single_add_req", ADD_REQ, 1);
    chk("single_add_a", ADD_A, 9'h0FF);
    chk("single_add_b", ADD_B, 9'h001);
    chk("single_busy", BUSY, 1);
    wait_ack(n);
    chk("single_latency", n + 1, 3);
    chk("single_ack", ACK, 3'b001);
    chk("single_z", Z_OUT, 9'h100);
    chk("single_cout", COUT_OUT, 0);
    chk("single_err", ERR, 0);
    chk("single_req_drop", ADD_REQ, 0);
    tick();
    chk("single_ack_pulse", ACK, 0);

    // held request: no re-grant until REQ0 drops
    seen = 0;
    repeat (8) begin tick(); if (ADD_REQ) seen = 1; end
    chk("held_no_regrant", seen, 0);
    chk("held_add_a_hold", ADD_A, 9'h0FF);
    chk("held_z_hold", Z_OUT, 9'h100);
    REQ = 3'b000;
    tick();
    REQ = 3'b001;
    wait_ack(n);
    chk("regrant_latency", n, 3);
    chk("regrant_ack", ACK, 3'b001);
    REQ = 3'b000;

    // stray ADD_ACK in IDLE is ignored
    wait_idle();
    en_m = 1'b0;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_ack", ACK, 0);
    chk("spur_busy", BUSY, 0);
    tick();
    chk("spur_ack2", ACK, 0);
    chk("spur_z", Z_OUT, 9'h100);

    // timeout: adder silent
    REQ = 3'b100;
    n = 0; hi = 0;
    while (ACK == 3'b000 && n < 60) begin
      tick(); n++;
      if (ADD_REQ) hi++;
    end
    chk("tmo_latency", n, 16);
    chk("tmo_issue_cycles", hi, 15);
    chk("tmo_ack", ACK, 3'b100);
    chk("tmo_err", ERR, 1);
    chk("tmo_z", Z_OUT, 0);
    chk("tmo_cout", COUT_OUT, 0);
    chk("tmo_add_req", ADD_REQ, 0);
    tick();
    chk("tmo_err_pulse", ERR, 0);
    REQ  = 3'b000;
    en_m = 1'b1;

    // carry out on requester 1
    wait_idle();
    REQ = 3'b010;
    wait_ack(n);
    chk("carry_latency", n, 3);
    chk("carry_ack", ACK, 3'b010);
    chk("carry_z", Z_OUT, 9'h000);
    chk("carry_cout", COUT_OUT, 1);
    REQ = 3'b000;

    // reset while in ISSUE
    wait_idle();
    REQ = 3'b010;
    tick();
    chk("rsti_add_req", ADD_REQ, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rsti_ack", ACK, 0);
    chk("rsti_err", ERR, 0);
    chk("rsti_add_req_low", ADD_REQ, 0);
    chk("rsti_add_a", ADD_A, 0);
    chk("rsti_add_b", ADD_B, 0);
    chk("rsti_cout", COUT_OUT, 0);
    chk("rsti_busy", BUSY, 1);
    REQ = 3'b111;
    low = 1; n = 0;
    while (!ADD_REQ && n < 20) begin
      tick(); n++;
      if (!ADD_REQ) low++;
    end
    chk("rsti_low_ge2", {31'd0, low >= 2}, 1);
    chk("rsti_first_grant_a", ADD_A, 9'h0FF);

    // contention: each requester drops REQ for one cycle after its ACK
    k = 0; last = 0; n = 0;
    while (k < 4 && n < 80) begin
      tick(); n++;
      REQ = 3'b111;
      if (ACK != 3'b000) begin
        idx = (ACK == 3'b001) ? 0 : (ACK == 3'b010) ? 1 : (ACK == 3'b100) ? 2 : 3;
        exp_z = (k % 3 == 0) ? 9'h100 : (k % 3 == 1) ? 9'h000 : 9'h0FF;
        chk($sformatf("cont_order%0d", k), idx, k % 3);
        chk($sformatf("cont_z%0d", k), Z_OUT, exp_z);
        if (k > 0) chk($sformatf("cont_spacing%0d", k), cyc - last, 5);
        last = cyc;
        k++;
        REQ = REQ & ~ACK;
      end
    end
    chk("cont_count", k, 4);
    REQ = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 9, which sets the operand and result width and matches the shared adder.
REQ-002 The block SHALL have parameter TMO, default 15, which sets the maximum number of ISSUE cycles spent waiting for ADD_ACK.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The ports SHALL be as follows:
- CLK  in  1  clock; all state updates on the posedge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  3  per-requester request, 4-phase.
- A_IN  in  3*W  operand A; requester i uses bits [i*W +: W].
- B_IN  in  3*W  operand B; same packing as A_IN.
- ACK  out  3  per-requester one-cycle completion pulse.
- Z_OUT  out  W  result of the most recent operation.
- COUT_OUT  out  1  carry of the most recent operation.
- ERR  out  1  one-cycle pulse on adder timeout.
- BUSY  out  1  high in any state other than IDLE.
- ADD_A, ADD_B  out  W each  operands to the adder.
- ADD_REQ  out  1  request to the adder.
- ADD_Z  in  W  adder result.
- ADD_COUT  in  1  adder carry.
- ADD_ACK  in  1  adder one-cycle acknowledge.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, RELEASE and GAP, and all outputs SHALL be registered.
REQ-006 Requester i SHALL be eligible when REQ[i]=1 and its per-requester "wait-low" flag is clear.
REQ-007 In IDLE with at least one requester eligible, the FSM SHALL grant by round-robin starting from pointer PTR, latch that requester's operands into ADD_A/ADD_B, set ADD_REQ=1, enter ISSUE, and set PTR=(grant+1) mod 3.
REQ-008 In IDLE with no requester eligible, the FSM SHALL stay in IDLE with ADD_REQ=0.
REQ-009 In ISSUE, ADD_REQ and ADD_A/ADD_B SHALL be held stable until ADD_ACK=1 is sampled.
REQ-010 On sampling ADD_ACK=1 in ISSUE, the block SHALL register Z_OUT=ADD_Z and COUT_OUT=ADD_COUT, pulse ACK[grant] for 1 cycle, drop ADD_REQ, set wait-low[grant], and enter RELEASE.
REQ-011 If ADD_ACK has not been seen after TMO cycles in ISSUE, the block SHALL take the REQ-010 actions but with Z_OUT=0, COUT_OUT=0 and ERR pulsed in the same cycle as ACK[grant].
REQ-012 RELEASE SHALL last 1 cycle with ADD_REQ=0 and then go to GAP; GAP SHALL last 1 cycle and then go to IDLE. This guarantees the adder is back in its compute state before the next ADD_REQ.
REQ-013 Timing SHALL be as follows: grant in IDLE at cycle t, then ADD_REQ=1 at t+1, ADD_ACK seen at t+2, ACK[i]=1 at t+3. Peak throughput is one operation per 5 cycles.
REQ-014 wait-low[i] SHALL clear in any cycle where REQ[i]=0, so a requester is re-granted only after it drops REQ, giving a 4-phase handshake.
REQ-015 Z_OUT and COUT_OUT SHALL hold their value until the next completion, and ADD_A/ADD_B SHALL hold their value until the next grant.
REQ-016 The arithmetic SHALL be performed entirely by the adder; the block SHALL never modify operands or results.
REQ-017 ADD_ACK SHALL be ignored in IDLE, RELEASE and GAP, with no state change and no ACK.
REQ-018 If REQ[grant] drops while in ISSUE, the operation SHALL still complete and ACK SHALL still pulse, and wait-low SHALL clear on the next cycle.
REQ-019 With all three requesters continuously eligible, the grant order SHALL be 0,1,2,0,... from reset.

Reset
REQ-020 When RST=1 at a clock edge, the block SHALL set the FSM to RELEASE, PTR=0, all wait-low flags=0, ACK=0, ERR=0, ADD_REQ=0, ADD_A=0, ADD_B=0, Z_OUT=0, COUT_OUT=0 and the timeout counter=0.
REQ-021 BUSY SHALL be 1 out of reset until the FSM reaches IDLE.
REQ-022 Reset SHALL take priority over every event, including an in-flight ADD_ACK.
REQ-023 The RELEASE-then-GAP sequence after reset SHALL guarantee at least 2 cycles of ADD_REQ=0 before the first issue, so an adder left mid-handshake recovers.

Verification
REQ-024 The bench SHALL cover a single request: REQ=001, A0=0x0FF, B0=0x001 -> ACK=001 exactly 3 cycles after grant, Z_OUT=0x100, COUT_OUT=0.
REQ-025 The bench SHALL cover carry out: A1=0x1FF, B1=0x001 -> Z_OUT=0x000, COUT_OUT=1, ACK[1] pulse only.
REQ-026 The bench SHALL cover contention: REQ=111 held, with each requester dropping REQ for 1 cycle after its ACK -> ACK order 0,1,2,0, with 5-cycle spacing between ACK pulses.
REQ-027 The bench SHALL cover a held request: REQ0 stays high after ACK -> no second grant to requester 0 until REQ0 is low for 1 cycle.
REQ-028 The bench SHALL cover timeout: the adder model never asserts ADD_ACK -> after 15 ISSUE cycles, ERR=1 and ACK[i]=1 in the same cycle, Z_OUT=0, and ADD_REQ falls.
REQ-029 The bench SHALL cover reset in ISSUE: RST high for 1 cycle -> all outputs 0, ADD_REQ low for at least 2 cycles, and the next grant goes to requester 0.
